// File: rtl/vec_register_file.sv
// Vector register file: NUM_REGS vectors of NUM_LANES x ELEM_WIDTH lanes,
// two combinational read ports and one synchronous full-vector write port.
module vec_register_file #(
  parameter int NUM_REGS   = 8,
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_LANES  = 4,
  localparam int SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 regWrEn,
  input  logic [SEL_W-1:0]                     rSel1,
  input  logic [SEL_W-1:0]                     rSel2,
  input  logic [SEL_W-1:0]                     regToWrite,
  input  logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] regWriteData,
  output logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] reg1Out,
  output logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] reg2Out
);

  logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_LANES-1:0][ELEM_WIDTH-1:0] regs_d [NUM_REGS];

  // Indices are matched by compare so an out-of-range write target
  // (non power-of-two NUM_REGS) simply hits no entry and is dropped.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (regWrEn && (regToWrite == SEL_W'(i))) begin
        regs_d[i] = regWriteData;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read mux without write bypass; unmatched (out-of-range) selects read 0.
  always_comb begin
    reg1Out = '0;
    reg2Out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rSel1 == SEL_W'(i)) begin
        reg1Out = regs_q[i];
      end
      if (rSel2 == SEL_W'(i)) begin
        reg2Out = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_vec_register_file.sv
// Bench for vec_register_file at default parameters: directed scenarios plus
// randomized traffic checked against an array-of-words reference model.
module tb_vec_register_file;

  logic            clk = 1'b0;
  logic            reset;
  logic            regWrEn;
  logic [2:0]      rSel1, rSel2, regToWrite;
  logic [3:0][7:0] regWriteData;
  logic [3:0][7:0] reg1Out, reg2Out;

  logic [31:0] model [8];
  int passed = 0;
  int total  = 0;

  vec_register_file #(8, 8, 4) dut (
    .clk          (clk),
    .reset        (reset),
    .regWrEn      (regWrEn),
    .rSel1        (rSel1),
    .rSel2        (rSel2),
    .regToWrite   (regToWrite),
    .regWriteData (regWriteData),
    .reg1Out      (reg1Out),
    .reg2Out      (reg2Out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; regWrEn = 1'b1; regToWrite = 3'd2; regWriteData = 32'hCAFEF00D;
    rSel1 = 3'd0; rSel2 = 3'd0;
    repeat (2) @(posedge clk);
    #2;
    regWrEn = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      rSel1 = 3'(i); rSel2 = 3'(7 - i);
      #1;
      total++;
      if (reg1Out !== model[i]) $display("FAIL reset_r1[%0d] got %h want %h", i, reg1Out, model[i]);
      else passed++;
      total++;
      if (reg2Out !== model[7 - i]) $display("FAIL reset_r2[%0d] got %h want %h", 7 - i, reg2Out, model[7 - i]);
      else passed++;
    end
  endtask

  task automatic test_write_basic();
    step();
    regWrEn = 1'b1; regToWrite = 3'd1; regWriteData = 32'hDEADBEEF;
    rSel1 = 3'd1; rSel2 = 3'd0;
    #1;
    total++;
    if (reg1Out !== 32'h0) $display("FAIL pre_edge_r1 got %h want %h", reg1Out, 32'h0);
    else passed++;
    step();
    model[1] = 32'hDEADBEEF;
    regWrEn = 1'b0;
    #1;
    total++;
    if (reg1Out !== model[1]) $display("FAIL write1_r1 got %h want %h", reg1Out, model[1]);
    else passed++;
    total++;
    if (reg1Out[3] !== 8'hDE || reg1Out[2] !== 8'hAD || reg1Out[1] !== 8'hBE || reg1Out[0] !== 8'hEF)
      $display("FAIL lane_order got %h %h %h %h want de ad be ef", reg1Out[3], reg1Out[2], reg1Out[1], reg1Out[0]);
    else passed++;
    total++;
    if (reg2Out !== 32'h0) $display("FAIL write1_r2 got %h want %h", reg2Out, 32'h0);
    else passed++;

    regWrEn = 1'b1; regToWrite = 3'd7; regWriteData = 32'h1A2B3C4D; rSel1 = 3'd7;
    step();
    model[7] = 32'h1A2B3C4D;
    regWrEn = 1'b0;
    #1;
    total++;
    if (reg1Out !== model[7]) $display("FAIL write7_r1 got %h want %h", reg1Out, model[7]);
    else passed++;
    total++;
    if (reg2Out !== model[0]) $display("FAIL write7_r2 got %h want %h", reg2Out, model[0]);
    else passed++;
  endtask

  task automatic test_dual_read();
    rSel1 = 3'd1; rSel2 = 3'd7;
    #1;
    total++;
    if (reg1Out !== 32'hDEADBEEF) $display("FAIL dual_r1 got %h want %h", reg1Out, 32'hDEADBEEF);
    else passed++;
    total++;
    if (reg2Out !== 32'h1A2B3C4D) $display("FAIL dual_r2 got %h want %h", reg2Out, 32'h1A2B3C4D);
    else passed++;
    rSel1 = 3'd7;
    #1;
    total++;
    if (reg1Out !== 32'h1A2B3C4D || reg2Out !== 32'h1A2B3C4D)
      $display("FAIL same_sel got %h/%h want %h", reg1Out, reg2Out, 32'h1A2B3C4D);
    else passed++;
  endtask

  task automatic test_write_disable();
    regWrEn = 1'b0; regToWrite = 3'd1; regWriteData = 32'hFFFFFFFF; rSel1 = 3'd1; rSel2 = 3'd1;
    repeat (3) step();
    total++;
    if (reg1Out !== model[1]) $display("FAIL wren0_hold got %h want %h", reg1Out, model[1]);
    else passed++;
    regWriteData = 32'h01020304; regWrEn = 1'b1;
    #1;
    total++;
    if (reg1Out !== 32'hDEADBEEF) $display("FAIL no_bypass got %h want %h", reg1Out, 32'hDEADBEEF);
    else passed++;
    step();
    model[1] = 32'h01020304;
    regWrEn = 1'b0;
    #1;
    total++;
    if (reg1Out !== model[1] || reg2Out !== model[1])
      $display("FAIL after_edge got %h/%h want %h", reg1Out, reg2Out, model[1]);
    else passed++;
  endtask

  task automatic test_reg0_writable();
    regWrEn = 1'b1; regToWrite = 3'd0; regWriteData = 32'h5A5AA5A5; rSel1 = 3'd0; rSel2 = 3'd1;
    step();
    model[0] = 32'h5A5AA5A5;
    regWrEn = 1'b0;
    #1;
    total++;
    if (reg1Out !== model[0]) $display("FAIL reg0_write got %h want %h", reg1Out, model[0]);
    else passed++;
    total++;
    if (reg2Out !== model[1]) $display("FAIL reg0_other got %h want %h", reg2Out, model[1]);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      regWrEn      = ($urandom_range(0, 3) != 0);
      regToWrite   = 3'($urandom_range(0, 7));
      regWriteData = $urandom;
      rSel1        = ($urandom_range(0, 3) == 0) ? regToWrite : 3'($urandom_range(0, 7));
      rSel2        = 3'($urandom_range(0, 7));
      #1;
      total++;
      if (reg1Out !== model[rSel1] || reg2Out !== model[rSel2])
        $display("FAIL rand_pre[%0d] got %h/%h want %h/%h", n, reg1Out, reg2Out, model[rSel1], model[rSel2]);
      else passed++;
      step();
      if (regWrEn) model[regToWrite] = regWriteData;
      #1;
      total++;
      if (reg1Out !== model[rSel1] || reg2Out !== model[rSel2])
        $display("FAIL rand_post[%0d] got %h/%h want %h/%h", n, reg1Out, reg2Out, model[rSel1], model[rSel2]);
      else passed++;
    end
    regWrEn = 1'b0;
  endtask

  task automatic test_async_reset();
    regWrEn = 1'b1; regToWrite = 3'd7; regWriteData = 32'h11223344; rSel1 = 3'd1; rSel2 = 3'd7;
    model[1] = 32'hDEADBEEF;
    model[7] = 32'h1A2B3C4D;
    step();
    regWrEn = 1'b0;
    #1;
    total++;
    if (reg1Out === 32'h0 && reg2Out === 32'h0) $display("FAIL pre_reset_nonzero got %h/%h want nonzero", reg1Out, reg2Out);
    else passed++;
    #1;
    regWrEn = 1'b1; regToWrite = 3'd7; regWriteData = 32'h99887766;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    #1;
    total++;
    if (reg1Out !== 32'h0 || reg2Out !== 32'h0) $display("FAIL async_clear got %h/%h want 0/0", reg1Out, reg2Out);
    else passed++;
    step();
    #2;
    reset = 1'b0;
    regWrEn = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      rSel1 = 3'(i); rSel2 = 3'(i);
      #1;
      total++;
      if (reg1Out !== model[i] || reg2Out !== model[i])
        $display("FAIL post_reset[%0d] got %h/%h want %h", i, reg1Out, reg2Out, model[i]);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1; regWrEn = 1'b0; rSel1 = '0; rSel2 = '0; regToWrite = '0; regWriteData = '0;
    test_reset();
    test_write_basic();
    test_dual_read();
    test_write_disable();
    test_async_reset();
    test_reg0_writable();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
